// File: rtl/router_pkg.sv
// Shared router definitions: flit field positions, flit types and framing helpers.
package router_pkg;

  localparam int unsigned DEFAULT_FLIT_W = 32;

  localparam int unsigned DEST_MSB = 31;
  localparam int unsigned DEST_LSB = 24;
  localparam int unsigned TYPE_MSB = 23;
  localparam int unsigned TYPE_LSB = 22;

  localparam logic [1:0] FT_BODY   = 2'b00;
  localparam logic [1:0] FT_HEAD   = 2'b01;
  localparam logic [1:0] FT_TAIL   = 2'b10;
  localparam logic [1:0] FT_SINGLE = 2'b11;

  typedef enum logic {
    FR_IDLE = 1'b0,
    FR_BUSY = 1'b1
  } frame_state_t;

  // Next framing state for a granted flit of type ft.
  function automatic frame_state_t frame_next(frame_state_t s, logic [1:0] ft);
    frame_state_t n;
    case (ft)
      FT_HEAD:   n = FR_BUSY;
      FT_SINGLE: n = FR_IDLE;
      FT_TAIL:   n = FR_IDLE;
      default:   n = s;
    endcase
    return n;
  endfunction

  // True when flit type ft is illegal in framing state s.
  function automatic logic frame_err(frame_state_t s, logic [1:0] ft);
    logic e;
    if (s == FR_IDLE) e = (ft == FT_BODY) || (ft == FT_TAIL);
    else              e = (ft == FT_HEAD) || (ft == FT_SINGLE);
    return e;
  endfunction

endpackage

// File: rtl/vc_credit_counter.sv
// Saturating per-VC credit counter with a sticky overflow flag.
module vc_credit_counter #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          dec,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          overflow
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Count consumed slots down and returned slots up; a return into a full counter saturates and flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= FULL;
      overflow <= 1'b0;
    end else if (inc && !dec) begin
      if (cnt == FULL) overflow <= 1'b1;
      else             cnt      <= cnt + CW'(1);
    end else if (dec && !inc && cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/vc_link_scheduler.sv
// Credit-aware round-robin scheduler of two VC buffers onto one output link.
module vc_link_scheduler
  import router_pkg::*;
#(
  parameter int unsigned FLIT_W       = DEFAULT_FLIT_W,
  parameter int unsigned CREDIT_DEPTH = 4,
  parameter int unsigned CW           = $clog2(CREDIT_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vc0_valid,
  input  logic [FLIT_W-1:0] vc0_flit,
  input  logic              vc1_valid,
  input  logic [FLIT_W-1:0] vc1_flit,
  output logic              vc0_pop,
  output logic              vc1_pop,
  input  logic [1:0]        credit_in,
  output logic              out_valid,
  output logic [FLIT_W-1:0] out_flit,
  output logic              out_vc,
  output logic [CW-1:0]     credit_cnt0,
  output logic [CW-1:0]     credit_cnt1,
  output logic              proto_err,
  output logic              credit_err
);

  logic         last_gnt;
  logic         elig0, elig1;
  logic         gnt0, gnt1;
  logic         ovf0, ovf1;
  logic [1:0]   ft0, ft1;
  frame_state_t fr0, fr1;

  assign ft0 = vc0_flit[TYPE_MSB:TYPE_LSB];
  assign ft1 = vc1_flit[TYPE_MSB:TYPE_LSB];

  // Eligibility and round-robin grant; on a tie the VC not granted last wins.
  always_comb begin
    elig0 = vc0_valid && (credit_cnt0 != '0);
    elig1 = vc1_valid && (credit_cnt1 != '0);
    gnt0  = elig0 && (!elig1 || last_gnt);
    gnt1  = elig1 && (!elig0 || !last_gnt);
  end

  assign vc0_pop    = gnt0;
  assign vc1_pop    = gnt1;
  assign credit_err = ovf0 | ovf1;

  vc_credit_counter #(.DEPTH(CREDIT_DEPTH), .CW(CW)) u_cc0 (
    .clk      (clk),
    .reset    (reset),
    .dec      (gnt0),
    .inc      (credit_in[0]),
    .cnt      (credit_cnt0),
    .overflow (ovf0)
  );

  vc_credit_counter #(.DEPTH(CREDIT_DEPTH), .CW(CW)) u_cc1 (
    .clk      (clk),
    .reset    (reset),
    .dec      (gnt1),
    .inc      (credit_in[1]),
    .cnt      (credit_cnt1),
    .overflow (ovf1)
  );

  // Link register, grant pointer and per-VC framing checks on granted flits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_flit  <= '0;
      out_vc    <= 1'b0;
      last_gnt  <= 1'b1;
      fr0       <= FR_IDLE;
      fr1       <= FR_IDLE;
      proto_err <= 1'b0;
    end else begin
      out_valid <= gnt0 | gnt1;
      if (gnt0) begin
        out_flit <= vc0_flit;
        out_vc   <= 1'b0;
        last_gnt <= 1'b0;
        fr0      <= frame_next(fr0, ft0);
        if (frame_err(fr0, ft0)) proto_err <= 1'b1;
      end else if (gnt1) begin
        out_flit <= vc1_flit;
        out_vc   <= 1'b1;
        last_gnt <= 1'b1;
        fr1      <= frame_next(fr1, ft1);
        if (frame_err(fr1, ft1)) proto_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vc_link_scheduler.sv
// Directed self-checking bench for vc_link_scheduler.
module tb_vc_link_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        vc0_valid, vc1_valid;
  logic [31:0] vc0_flit, vc1_flit;
  logic        vc0_pop, vc1_pop;
  logic [1:0]  credit_in;
  logic        out_valid;
  logic [31:0] out_flit;
  logic        out_vc;
  logic [2:0]  credit_cnt0, credit_cnt1;
  logic        proto_err, credit_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vc_link_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .vc0_valid   (vc0_valid),
    .vc0_flit    (vc0_flit),
    .vc1_valid   (vc1_valid),
    .vc1_flit    (vc1_flit),
    .vc0_pop     (vc0_pop),
    .vc1_pop     (vc1_pop),
    .credit_in   (credit_in),
    .out_valid   (out_valid),
    .out_flit    (out_flit),
    .out_vc      (out_vc),
    .credit_cnt0 (credit_cnt0),
    .credit_cnt1 (credit_cnt1),
    .proto_err   (proto_err),
    .credit_err  (credit_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_flit"}, out_flit, 32'd0);
    check({tag, "_out_vc"}, 32'(out_vc), 32'd0);
    check({tag, "_cnt0"}, 32'(credit_cnt0), 32'd4);
    check({tag, "_cnt1"}, 32'(credit_cnt1), 32'd4);
    check({tag, "_proto_err"}, 32'(proto_err), 32'd0);
    check({tag, "_credit_err"}, 32'(credit_err), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    vc0_valid = 1'b0; vc1_valid = 1'b0;
    vc0_flit = '0; vc1_flit = '0;
    credit_in = 2'b00;
    #12;
    check_reset_state("rst");
    step();
    reset = 1'b0;

    // Round-robin with both VCs busy; credits returned to the granted VC.
    vc0_valid = 1'b1; vc1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vc0_flit = 32'hA0C0_0000 + 32'(i);
      vc1_flit = 32'hB1C0_0000 + 32'(i);
      credit_in = (i % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      check("rr_pop0", 32'(vc0_pop), (i % 2 == 0) ? 32'd1 : 32'd0);
      check("rr_pop1", 32'(vc1_pop), (i % 2 == 0) ? 32'd0 : 32'd1);
      step();
      check("rr_out_valid", 32'(out_valid), 32'd1);
      check("rr_out_vc", 32'(out_vc), (i % 2 == 0) ? 32'd0 : 32'd1);
      check("rr_out_flit", out_flit, (i % 2 == 0) ? 32'hA0C0_0000 + 32'(i) : 32'hB1C0_0000 + 32'(i));
    end
    check("rr_cnt0", 32'(credit_cnt0), 32'd4);
    check("rr_cnt1", 32'(credit_cnt1), 32'd4);
    check("rr_credit_err", 32'(credit_err), 32'd0);

    // VC0 alone with no returns: exactly four pops.
    vc1_valid = 1'b0;
    credit_in = 2'b00;
    for (int i = 0; i < 4; i++) begin
      vc0_flit = 32'hA0C0_0010 + 32'(i);
      #1;
      check("drain_pop0", 32'(vc0_pop), 32'd1);
      step();
      check("drain_cnt0", 32'(credit_cnt0), 32'(3 - i));
      check("drain_out_valid", 32'(out_valid), 32'd1);
    end
    vc0_flit = 32'hA0C0_0020;
    #1;
    check("empty_pop0", 32'(vc0_pop), 32'd0);
    step();
    check("empty_out_valid", 32'(out_valid), 32'd0);
    check("empty_out_flit_hold", out_flit, 32'hA0C0_0013);
    credit_in = 2'b01;
    #1;
    check("ret_pop0_same_cycle", 32'(vc0_pop), 32'd0);
    step();
    credit_in = 2'b00;
    check("ret_cnt0", 32'(credit_cnt0), 32'd1);
    #1;
    check("ret_pop0_next", 32'(vc0_pop), 32'd1);
    step();
    check("ret_cnt0_used", 32'(credit_cnt0), 32'd0);
    check("ret_out_flit", out_flit, 32'hA0C0_0020);

    // VC0 stuck at zero credits: VC1 served every cycle.
    vc1_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vc1_flit = 32'hB1C0_0010 + 32'(i);
      #1;
      check("v1_pop0", 32'(vc0_pop), 32'd0);
      check("v1_pop1", 32'(vc1_pop), 32'd1);
      step();
      check("v1_cnt1", 32'(credit_cnt1), 32'(3 - i));
      check("v1_out_vc", 32'(out_vc), 32'd1);
    end
    // Last credit consumed and returned in the same cycle.
    credit_in = 2'b10;
    #1;
    check("same_pop1", 32'(vc1_pop), 32'd1);
    step();
    credit_in = 2'b00;
    check("same_cnt1", 32'(credit_cnt1), 32'd1);
    #1;
    check("same_still_elig", 32'(vc1_pop), 32'd1);
    vc0_valid = 1'b0; vc1_valid = 1'b0;

    // Refill both counters.
    credit_in = 2'b11;
    for (int i = 0; i < 3; i++) step();
    credit_in = 2'b01;
    step();
    check("refill_cnt0", 32'(credit_cnt0), 32'd4);
    check("refill_cnt1", 32'(credit_cnt1), 32'd4);
    check("refill_credit_err", 32'(credit_err), 32'd0);

    // Return into a full counter.
    step();
    credit_in = 2'b00;
    check("ovf_credit_err", 32'(credit_err), 32'd1);
    check("ovf_cnt0", 32'(credit_cnt0), 32'd4);
    step();
    check("ovf_sticky", 32'(credit_err), 32'd1);

    // Legal framing on VC0.
    vc0_valid = 1'b1;
    credit_in = 2'b01;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: vc0_flit = 32'h0A40_0001;
        1: vc0_flit = 32'h0A00_0002;
        2: vc0_flit = 32'h0A80_0003;
        default: vc0_flit = 32'h0AC0_0004;
      endcase
      #1;
      check("frm_pop0", 32'(vc0_pop), 32'd1);
      step();
      check("frm_proto_err", 32'(proto_err), 32'd0);
      check("frm_out_flit", out_flit, 32'h0A00_0001 + 32'(i) + ((i == 0) ? 32'h0040_0000 : (i == 2) ? 32'h0080_0000 : (i == 3) ? 32'h00C0_0000 : 32'h0));
    end
    // BODY on an idle VC1.
    vc0_valid = 1'b0;
    vc1_valid = 1'b1;
    vc1_flit = 32'h0B00_0005;
    credit_in = 2'b10;
    #1;
    check("bad_pop1", 32'(vc1_pop), 32'd1);
    step();
    vc1_valid = 1'b0;
    credit_in = 2'b00;
    check("bad_proto_err", 32'(proto_err), 32'd1);
    check("bad_out_vc", 32'(out_vc), 32'd1);
    step();
    check("bad_sticky", 32'(proto_err), 32'd1);

    // Reset in the middle of a VC0 packet.
    vc0_valid = 1'b1;
    vc0_flit = 32'h0CC0_0006;
    step();
    vc0_flit = 32'h0C40_0007;
    step();
    vc0_valid = 1'b0;
    check("mid_cnt0", 32'(credit_cnt0), 32'd2);
    check("mid_out_flit", out_flit, 32'h0C40_0007);
    #2;
    reset = 1'b1;
    #1;
    check_reset_state("mid_rst");
    step();
    reset = 1'b0;
    vc0_valid = 1'b1;
    vc0_flit = 32'h0D40_0008;
    #1;
    check("post_pop0", 32'(vc0_pop), 32'd1);
    step();
    check("post_out_valid", 32'(out_valid), 32'd1);
    check("post_proto_err", 32'(proto_err), 32'd0);
    check("post_cnt0", 32'(credit_cnt0), 32'd3);
    vc0_flit = 32'h0D80_0009;
    step();
    vc0_valid = 1'b0;
    check("post_tail_err", 32'(proto_err), 32'd0);
    check("post_tail_flit", out_flit, 32'h0D80_0009);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vc_link_scheduler.md
# vc_link_scheduler

Schedules flits from the two virtual-channel buffers of one router input onto a single shared output link, flit by flit, using round-robin arbitration gated by per-VC downstream credits. It sits between the per-VC input buffers and the link register, and replaces static VC0-first selection with fair, credit-aware selection. It also tracks head/body/tail framing per VC and flags protocol and credit errors.

## Interface
- `FLIT_W`, default 32: flit width. `[31:24]` = destination, `[23:22]` = flit type.
- `CREDIT_DEPTH`, default 4: downstream buffer slots per VC. Must be ≥ 1.
- `CW`, default `$clog2(CREDIT_DEPTH+1)`: credit counter width.
- `clk`, in, 1: clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `vc0_valid`, in, 1: VC0 buffer holds a flit.
- `vc0_flit`, in, FLIT_W: VC0 head-of-queue flit.
- `vc1_valid`, in, 1: VC1 buffer holds a flit.
- `vc1_flit`, in, FLIT_W: VC1 head-of-queue flit.
- `vc0_pop`, out, 1: combinational. VC0 flit is taken this cycle.
- `vc1_pop`, out, 1: combinational. VC1 flit is taken this cycle.
- `credit_in`, in, 2: one-cycle pulse per bit. The downstream side freed one slot of VC[i].
- `out_valid`, out, 1: registered. A link flit is valid.
- `out_flit`, out, FLIT_W: registered link flit.
- `out_vc`, out, 1: registered VC id of `out_flit`.
- `credit_cnt0`, out, CW: VC0 credit count.
- `credit_cnt1`, out, CW: VC1 credit count.
- `proto_err`, out, 1: sticky framing error.
- `credit_err`, out, 1: sticky credit overflow.

## Operation
- **Flit types** (`[23:22]`): `2'b01` HEAD, `2'b00` BODY, `2'b10` TAIL, `2'b11` SINGLE.
- **Eligibility:** `elig[i] = vci_valid && credit_cnt[i] != 0`.
- **Arbitration:** `last_gnt` is a 1-bit pointer.
  - Both VCs eligible: grant `!last_gnt`.
  - One VC eligible: grant that VC.
  - Neither eligible: no grant.
  - `last_gnt` updates only on a grant.
  - Arbitration is per flit. VCs may interleave mid-packet, since downstream buffers are per-VC.
- **Pop:** `vci_pop = grant[i]`. At most one pop per cycle.
- **Credit counters:** `next = cnt - grant[i] + credit_in[i]`.
  - Grant and return in the same cycle leave the count unchanged.
  - A return when `cnt == CREDIT_DEPTH` with no grant saturates the count at `CREDIT_DEPTH` and sets `credit_err`.
- **Per-VC framing FSM:** states IDLE and BUSY.
  - IDLE --HEAD--> BUSY.
  - IDLE --SINGLE--> IDLE.
  - BUSY --BODY--> BUSY.
  - BUSY --TAIL--> IDLE.
  - BODY or TAIL in IDLE sets `proto_err`; state stays IDLE.
  - HEAD or SINGLE in BUSY sets `proto_err`; HEAD stays BUSY, SINGLE goes to IDLE.
  - The FSM evaluates only granted flits.
- **Error flags:** `proto_err` and `credit_err` clear only on reset.

## Timing
- Reset values:
  - `out_valid=0`, `out_flit=0`, `out_vc=0`.
  - `credit_cnt0 = credit_cnt1 = CREDIT_DEPTH`.
  - `last_gnt=1`, so VC0 wins the first tie.
  - Both FSMs in IDLE.
  - `proto_err=0`, `credit_err=0`.
- Latency: a grant in cycle N gives `out_valid=1` with that flit in cycle N+1. With no grant in cycle N, `out_valid=0` in cycle N+1. `out_flit` holds its last value.
- Credit effect: a decrement is visible on `credit_cnt` in cycle N+1. `credit_in` in cycle N makes the VC eligible in cycle N+1 at the earliest.
- Throughput: one flit per cycle while credits last. Zero-credit VC0 with an eligible VC1 gives VC1 every cycle.
- Reset mid-packet: all state returns to reset values immediately. A flit in flight is dropped; upstream and downstream reset together.

## Structure
- `router_pkg` holds:
  - flit type localparams (`FT_HEAD`, `FT_BODY`, `FT_TAIL`, `FT_SINGLE`);
  - field positions `DEST_MSB/LSB`, `TYPE_MSB/LSB`;
  - default `FLIT_W`.
- One sub-module, `vc_credit_counter`, instantiated twice: saturating up/down counter with an overflow flag.
- Arbiter, framing FSMs and output register are inline.

## Test plan
- Reset, then both VCs valid continuously with credits returned each cycle → grants VC0, VC1, VC0, VC1. `out_vc` shows the same sequence one cycle later.
- Only VC0 valid, no `credit_in` → exactly 4 pops, then `vc0_pop=0` and `credit_cnt0=0`. Pulse `credit_in[0]` → one pop in the next cycle.
- `credit_cnt1=1`, VC1 granted while `credit_in[1]=1` in the same cycle → `credit_cnt1` stays 1 and VC1 stays eligible.
- `credit_in[0]` pulsed at `credit_cnt0=4` → `credit_err=1` (sticky) and `credit_cnt0` stays 4.
- VC0 sends HEAD, BODY, TAIL, SINGLE → `proto_err` stays 0. VC1 then sends BODY (`[23:22]=00`) while in IDLE → `proto_err=1` the next cycle.
- Assert reset after a HEAD on VC0 with `credit_cnt0=2` → all outputs return to reset values. A new HEAD after reset is accepted without error.
